// File: rtl/muldiv_ctl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also services MTHI/MTLO and MFHI/MFLO.
// Latency: mul/div result in HI/LO WIDTH+3 cycles after acceptance (divide-by-zero: 3); MTHI/MTLO one edge.
// Backpressure: stall_o holds EX while busy and a HI/LO consumer is present; flush_i aborts in-flight work.
module muldiv_ctl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             mf_req_i,
    input  logic             mf_sel_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] mf_data_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_MUL, S_DIV, S_FIX} state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [WIDTH-1:0]    r_opa;      // raw rs, kept for the divide-by-zero HI value
    logic [WIDTH-1:0]    r_opb;      // raw rt
    logic [WIDTH-1:0]    r_mag;      // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0]  r_acc;      // product, or {remainder, dividend/quotient}
    logic [CW-1:0]       r_cnt;
    logic                r_neg_q;    // negate product / quotient in FIX
    logic                r_neg_r;    // negate remainder in FIX
    logic                r_dbz;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;

    logic                w_muldiv_op;
    logic                w_hilo_op;
    logic                w_signed;
    logic                w_is_div;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [WIDTH:0]      w_msum;
    logic [WIDTH:0]      w_dr;
    logic [WIDTH:0]      w_ddiff;
    logic [2*WIDTH-1:0]  w_prod_fix;
    logic [WIDTH-1:0]    w_quo_fix;
    logic [WIDTH-1:0]    w_rem_fix;

    assign w_muldiv_op = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                         (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign w_hilo_op   = (op_i != 3'b000) && (op_i != 3'b111);

    // Operand conditioning for the latched op: signed ops work on magnitudes.
    assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_a_neg  = w_signed & r_opa[WIDTH-1];
    assign w_b_neg  = w_signed & r_opb[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -r_opa : r_opa;
    assign w_b_mag  = w_b_neg ? -r_opb : r_opb;

    // Shift-add step: add multiplicand to the upper half when the current multiplier bit is set.
    assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag} : '0);

    // Restoring-divide step: the shifted partial remainder is always below twice the divisor,
    // so bit WIDTH of the difference is a reliable borrow flag.
    assign w_dr    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ddiff = w_dr - {1'b0, r_mag};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Sequencer: acceptance, operand prep, iteration, sign fix-up and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 3'b000;
            r_opa   <= '0;
            r_opb   <= '0;
            r_mag   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (flush_i && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        if (w_muldiv_op) begin
                            r_op    <= op_i;
                            r_opa   <= rs_data_i;
                            r_opb   <= rt_data_i;
                            r_state <= S_PREP;
                        end else if (op_i == OP_MTHI) begin
                            r_hi <= rs_data_i;
                        end else if (op_i == OP_MTLO) begin
                            r_lo <= rs_data_i;
                        end
                    end
                end
                S_PREP: begin
                    r_cnt   <= CW'(WIDTH);
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_dbz   <= 1'b0;
                    if (!w_is_div) begin
                        r_mag   <= w_a_mag;
                        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                        r_state <= S_MUL;
                    end else if (r_opb == '0) begin
                        r_dbz   <= 1'b1;
                        r_state <= S_FIX;
                    end else begin
                        r_mag   <= w_b_mag;
                        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_state <= S_DIV;
                    end
                end
                S_MUL: begin
                    r_acc <= {w_msum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= S_FIX;
                end
                S_DIV: begin
                    if (!w_ddiff[WIDTH])
                        r_acc <= {w_ddiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    else
                        r_acc <= {w_dr[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_dbz) begin
                        r_hi <= r_opa;
                        r_lo <= '1;
                    end else if (w_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_FIX) && !flush_i;
    assign div_by_zero_o = done_o && r_dbz;
    assign stall_o       = busy_o && (mf_req_i || (start_i && w_hilo_op));
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign mf_data_o     = mf_sel_i ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_ctl.sv
// Scoreboard bench for muldiv_ctl: expected HI/LO queued at issue, compared after done_o.
// Latency: checks busy length, done position and post-done HI/LO visibility.
// Backpressure: exercises stall_o with MFHI and back-to-back starts.
module tb_muldiv_ctl;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        mf_req_i;
    logic        mf_sel_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic        div_by_zero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] mf_data_o;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_ctl #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .op_i          (op_i),
        .rs_data_i     (rs_data_i),
        .rt_data_i     (rt_data_i),
        .mf_req_i      (mf_req_i),
        .mf_sel_i      (mf_sel_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .mf_data_o     (mf_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue a mul/div at cycle T, then observe until one cycle after done_o (or budget).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output logic dbz);
        lat = -1; busy_cnt = 0; done_cnt = 0; dbz = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = OP_NONE;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    dbz = div_by_zero_o;
                end
            end
            if (lat >= 0 && k == lat + 1) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; rs_data_i = v;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = OP_NONE;
    endtask

    task automatic test_reset();
        int dseen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (hi_o !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected %h", hi_o, 32'h0); end
        n_vec++; if (lo_o !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected %h", lo_o, 32'h0); end
        n_vec++; if (busy_o !== 1'b0 || done_o !== 1'b0 || div_by_zero_o !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got busy=%b done=%b dbz=%b expected 0", busy_o, done_o, div_by_zero_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mt(OP_MTHI, 32'hDEAD);
        mt(OP_MTLO, 32'hBEEF);
        // MULT then reset for two edges mid-operation
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_MULT; rs_data_i = 32'hFFFF_FFFD; rt_data_i = 32'd5;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = OP_NONE;
        for (int k = 1; k <= 50; k++) begin
            rst_n = !(k == 10 || k == 11);
            @(negedge clk);
            if (done_o) dseen++;
            if (k == 12) begin
                n_vec++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
                    n_err++; $display("FAIL midreset_hilo: got %h_%h expected 0_0", hi_o, lo_o);
                end
                n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy_o); end
            end
            @(posedge clk); #1;
        end
        n_vec++; if (dseen != 0) begin n_err++; $display("FAIL midreset_done: got %0d pulses expected 0", dseen); end
        n_vec++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
            n_err++; $display("FAIL midreset_after: got %h_%h expected 0_0", hi_o, lo_o);
        end
    endtask

    task automatic test_multu();
        int lat, bc, dc; logic dbz; exp_t e;
        e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001; e.dbz = 1'b0;
        sb.push_back(e);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dc, dbz);
        e = sb.pop_front();
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL multu_lat: got %0d expected %0d", lat, 34); end
        n_vec++; if (bc != 34)  begin n_err++; $display("FAIL multu_busy: got %0d expected %0d", bc, 34); end
        n_vec++; if (dc != 1)   begin n_err++; $display("FAIL multu_done_cnt: got %0d expected %0d", dc, 1); end
        n_vec++; if (hi_o !== e.hi || lo_o !== e.lo) begin
            n_err++; $display("FAIL multu_result: got %h_%h expected %h_%h", hi_o, lo_o, e.hi, e.lo);
        end
    endtask

    task automatic test_mult();
        int lat, bc, dc; logic dbz; exp_t e;
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFF1; e.dbz = 1'b0;
        sb.push_back(e);
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bc, dc, dbz);
        e = sb.pop_front();
        n_vec++; if (hi_o !== e.hi || lo_o !== e.lo || dbz !== e.dbz) begin
            n_err++; $display("FAIL mult_neg: got %h_%h dbz=%b expected %h_%h dbz=%b", hi_o, lo_o, dbz, e.hi, e.lo, e.dbz);
        end
    endtask

    task automatic test_div();
        int lat, bc, dc; logic dbz; exp_t e;
        logic [2:0]  ops [3] = '{OP_DIV, OP_DIV, OP_DIVU};
        logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
        logic [31:0] bs  [3] = '{32'd2, 32'hFFFF_FFFF, 32'd0};
        exp_t        ex  [3];
        int          lats[3] = '{34, 34, 2};
        ex[0] = '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0};
        ex[1] = '{hi: 32'h0000_0000, lo: 32'h8000_0000, dbz: 1'b0};
        ex[2] = '{hi: 32'h0000_0007, lo: 32'hFFFF_FFFF, dbz: 1'b1};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex[i]);
            do_op(ops[i], as[i], bs[i], lat, bc, dc, dbz);
            e = sb.pop_front();
            n_vec++; if (lat != lats[i]) begin n_err++; $display("FAIL div%0d_lat: got %0d expected %0d", i, lat, lats[i]); end
            n_vec++; if (hi_o !== e.hi || lo_o !== e.lo || dbz !== e.dbz) begin
                n_err++; $display("FAIL div%0d_result: got %h_%h dbz=%b expected %h_%h dbz=%b", i, hi_o, lo_o, dbz, e.hi, e.lo, e.dbz);
            end
        end
    endtask

    task automatic test_mfhi_stall();
        int bad = 0; int dk = -1; exp_t e;
        e.hi = 32'h1; e.lo = 32'h0; e.dbz = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_MULTU; rs_data_i = 32'h0001_0000; rt_data_i = 32'h0001_0000;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = OP_NONE;
        mf_sel_i = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            mf_req_i = (k >= 3 && k <= 35);
            @(negedge clk);
            if (stall_o !== ((k >= 3 && k <= 34) ? 1'b1 : 1'b0)) bad++;
            if (done_o && dk < 0) dk = k;
            if (k == 35) begin
                e = sb.pop_front();
                n_vec++; if (mf_data_o !== e.hi) begin
                    n_err++; $display("FAIL mfhi_data: got %h expected %h", mf_data_o, e.hi);
                end
                n_vec++; if (lo_o !== e.lo) begin n_err++; $display("FAIL mfhi_lo: got %h expected %h", lo_o, e.lo); end
            end
            @(posedge clk); #1;
        end
        mf_req_i = 1'b0; mf_sel_i = 1'b0;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL mfhi_stall: got %0d wrong cycles expected 0", bad); end
        n_vec++; if (dk != 34) begin n_err++; $display("FAIL mfhi_done: got cycle %0d expected %0d", dk, 34); end
    endtask

    task automatic test_flush();
        int dseen = 0;
        mt(OP_MTHI, 32'hAAAA);
        mt(OP_MTLO, 32'h5555);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_DIV; rs_data_i = 32'd100; rt_data_i = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = OP_NONE;
        for (int k = 1; k <= 40; k++) begin
            flush_i = (k == 11);
            @(negedge clk);
            if (done_o) dseen++;
            if (k == 12) begin
                n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_idle: got busy=%b expected 0", busy_o); end
            end
            @(posedge clk); #1;
        end
        flush_i = 1'b0;
        n_vec++; if (dseen != 0) begin n_err++; $display("FAIL flush_done: got %0d expected 0", dseen); end
        n_vec++; if (hi_o !== 32'hAAAA || lo_o !== 32'h5555) begin
            n_err++; $display("FAIL flush_hilo: got %h_%h expected %h_%h", hi_o, lo_o, 32'hAAAA, 32'h5555);
        end
        // flush landing on the FIX cycle of a divide-by-zero
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_DIVU; rs_data_i = 32'd9; rt_data_i = 32'd0;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = OP_NONE;
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        n_vec++; if (done_o !== 1'b0 || div_by_zero_o !== 1'b0) begin
            n_err++; $display("FAIL flush_fix_done: got done=%b dbz=%b expected 0", done_o, div_by_zero_o);
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        n_vec++; if (busy_o !== 1'b0 || hi_o !== 32'hAAAA || lo_o !== 32'h5555) begin
            n_err++; $display("FAIL flush_fix_hilo: got busy=%b %h_%h expected 0 %h_%h", busy_o, hi_o, lo_o, 32'hAAAA, 32'h5555);
        end
        // flush with a start in IDLE, then with MTHI
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_MULTU; flush_i = 1'b1;
        @(posedge clk); #1;
        op_i = OP_MTHI; rs_data_i = 32'h777;
        @(negedge clk);
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_start: got busy=%b expected 0", busy_o); end
        @(posedge clk); #1;
        start_i = 1'b0; op_i = OP_NONE; flush_i = 1'b0;
        @(negedge clk);
        n_vec++; if (hi_o !== 32'hAAAA) begin n_err++; $display("FAIL flush_mthi: got %h expected %h", hi_o, 32'hAAAA); end
    endtask

    task automatic test_mtlo();
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_MTLO; rs_data_i = 32'h1234;
        @(negedge clk);
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL mtlo_stall: got %b expected 0", stall_o); end
        @(posedge clk); #1;
        start_i = 1'b0; op_i = OP_NONE; mf_req_i = 1'b1; mf_sel_i = 1'b0;
        @(negedge clk);
        n_vec++; if (mf_data_o !== 32'h1234 || stall_o !== 1'b0) begin
            n_err++; $display("FAIL mflo_data: got %h stall=%b expected %h stall=0", mf_data_o, stall_o, 32'h1234);
        end
        @(posedge clk); #1;
        mf_req_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad = 0; int d1 = -1; int d2 = -1; exp_t e;
        e = '{hi: 32'h0, lo: 32'd6, dbz: 1'b0};  sb.push_back(e);
        e = '{hi: 32'h0, lo: 32'd20, dbz: 1'b0}; sb.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = OP_MULT; rs_data_i = 32'd2; rt_data_i = 32'd3;
        @(posedge clk); #1;
        rs_data_i = 32'd4; rt_data_i = 32'd5;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            if (k <= 35 && stall_o !== ((k <= 34) ? 1'b1 : 1'b0)) bad++;
            if (done_o) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == 35) begin
                e = sb.pop_front();
                n_vec++; if (hi_o !== e.hi || lo_o !== e.lo) begin
                    n_err++; $display("FAIL b2b_first: got %h_%h expected %h_%h", hi_o, lo_o, e.hi, e.lo);
                end
            end
            if (k == 36) begin
                n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy=%b expected 1", busy_o); end
            end
            if (k == 70) begin
                e = sb.pop_front();
                n_vec++; if (hi_o !== e.hi || lo_o !== e.lo) begin
                    n_err++; $display("FAIL b2b_second: got %h_%h expected %h_%h", hi_o, lo_o, e.hi, e.lo);
                end
            end
            @(posedge clk); #1;
            if (k == 35) begin
                start_i = 1'b0; op_i = OP_NONE;
            end
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b_stall: got %0d wrong cycles expected 0", bad); end
        n_vec++; if (d1 != 34 || d2 != 69) begin
            n_err++; $display("FAIL b2b_done: got %0d,%0d expected 34,69", d1, d2);
        end
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; op_i = OP_NONE; rs_data_i = '0; rt_data_i = '0;
        mf_req_i = 1'b0; mf_sel_i = 1'b0; flush_i = 1'b0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_mfhi_stall();
        test_flush();
        test_mtlo();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
